// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its neighbour, the cache.
package fetch_unit_pkg;

  localparam int WORD_W = 32;

  // Request opcodes understood by the cache request port.
  localparam logic CACHE_READ  = 1'b0;
  localparam logic CACHE_WRITE = 1'b1;

  // One fetched instruction together with the word address it came from.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// Small synchronous FIFO with flush; head is visible combinationally.
// A flush empties the FIFO and wins over a push in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;
  logic          do_push;

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
  // when a pop frees the slot in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: walks the PC, issues word reads to the cache,
// pairs returned words with their PCs and queues them for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_op,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [WORD_W-1:0] resp_data,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [WORD_W-1:0] inst_pc,
  output logic [WORD_W-1:0] inst_data
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     in_flight_q, in_flight_d;
  logic [CW-1:0]     kill_q, kill_d;

  logic [CW-1:0]     iq_count;
  logic [CW-1:0]     pcf_count;
  logic [WORD_W-1:0] pcf_head;
  fetch_entry_t      iq_head;
  fetch_entry_t      iq_push_entry;

  logic              credit_ok;
  logic              issue;
  logic              resp_seen;
  logic              resp_accept;
  logic              deq;

  // Every outstanding request and every queued word holds one credit, so a
  // returning response always has a queue slot waiting for it.
  assign credit_ok   = ({1'b0, in_flight_q} + {1'b0, iq_count}) < (CW+1)'(QDEPTH);
  assign mem_valid   = !reset && !redirect_valid && credit_ok;
  assign issue       = mem_valid && mem_ready;
  assign resp_seen   = resp_valid && (in_flight_q != '0);
  // Responses are kept only when nothing stale is pending and no redirect is
  // discarding this cycle's work; a kept response consumes its PC record.
  assign resp_accept = resp_seen && !redirect_valid && (kill_q == '0) && (pcf_count != '0);
  assign deq         = inst_valid && inst_ready;

  // Next-state for the PC and the two outstanding-work counters.
  always_comb begin
    pc_d        = pc_q;
    in_flight_d = in_flight_q + CW'(issue) - CW'(resp_seen);
    kill_d      = kill_q;
    if (issue) begin
      pc_d = pc_q + 32'd1;
    end
    if (redirect_valid) begin
      // Whatever is still outstanding after this cycle belongs to the old
      // path and must be dropped on return.
      pc_d   = redirect_pc;
      kill_d = in_flight_d;
    end else if (resp_seen && (kill_q != '0)) begin
      kill_d = kill_q - CW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      in_flight_q <= '0;
      kill_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      in_flight_q <= in_flight_d;
      kill_q      <= kill_d;
    end
  end

  // PCs of requests on the live path, in issue order.
  fetch_queue #(
    .DEPTH (QDEPTH),
    .W     (WORD_W)
  ) u_pc_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (issue),
    .push_data_i (pc_q),
    .pop_i       (resp_accept),
    .flush_i     (redirect_valid),
    .head_o      (pcf_head),
    .count_o     (pcf_count)
  );

  assign iq_push_entry = '{pc: pcf_head, data: resp_data};

  // Instruction queue feeding decode.
  fetch_queue #(
    .DEPTH (QDEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_inst_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (resp_accept),
    .push_data_i (iq_push_entry),
    .pop_i       (deq),
    .flush_i     (redirect_valid),
    .head_o      (iq_head),
    .count_o     (iq_count)
  );

  assign mem_addr   = pc_q;
  assign mem_op     = CACHE_READ;
  assign mem_wdata  = '0;
  assign resp_ready = 1'b1;
  assign inst_valid = (iq_count != '0);
  assign inst_pc    = iq_head.pc;
  assign inst_data  = iq_head.data;

endmodule
